cp0_exc_ctrl: RTL and testbench

Coprocessor-0 register file plus exception/interrupt entry and return sequencer for the 5-stage MIPS pipeline.
- Consumes the M-stage exception bundle (valid, ExcCode, branch-delay flag, PC), hardware interrupts and ERET.
- Latches SR/Cause/EPC, flushes the pipeline for a fixed number of cycles, then issues a one-cycle PC redirect to the handler, or to EPC on ERET.

---
 rtl/cp0_pkg.sv | 40 ++++
 rtl/cp0_regs.sv | 107 ++++++++++
 rtl/cp0_exc_ctrl.sv | 140 ++++++++++++++
 tb/tb_cp0_exc_ctrl.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cp0_pkg.sv
// Shared constants for the CP0 exception controller: register numbers,
// ExcCode values, FSM state encoding and SR/Cause field positions.
package cp0_pkg;

  // CP0 register numbers
  localparam logic [4:0] CP0_CNT   = 5'd9;
  localparam logic [4:0] CP0_SR    = 5'd12;
  localparam logic [4:0] CP0_CAUSE = 5'd13;
  localparam logic [4:0] CP0_EPC   = 5'd14;
  localparam logic [4:0] CP0_PRID  = 5'd15;

  // ExcCode values
  localparam logic [4:0] EXC_INT  = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_RI   = 5'd10;
  localparam logic [4:0] EXC_OV   = 5'd12;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  // SR / Cause field positions
  localparam int SR_IE_BIT     = 0;
  localparam int SR_EXL_BIT    = 1;
  localparam int SR_IM_LSB     = 10;
  localparam int SR_IM_MSB     = 15;
  localparam int CAUSE_EXC_LSB = 2;
  localparam int CAUSE_EXC_MSB = 6;
  localparam int CAUSE_IP_LSB  = 10;
  localparam int CAUSE_IP_MSB  = 15;
  localparam int CAUSE_BD_BIT  = 31;

  // EPC is always word aligned
  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/cp0_regs.sv
// SR, Cause and EPC storage with exception-entry/ERET/MTC0 update muxing
// and the combinational CP0 read mux (PRId is a constant).
module cp0_regs
  import cp0_pkg::*;
#(
  parameter logic [31:0] PRID_VAL = 32'h1823_1051
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  hw_int,
  input  logic        take,
  input  logic [4:0]  exc_code,
  input  logic        bd,
  input  logic [31:0] pc,
  input  logic        eret_do,
  input  logic        wr_en,
  input  logic [4:0]  addr,
  input  logic [31:0] wdata,
  output logic [5:0]  sr_im,
  output logic        sr_exl,
  output logic        sr_ie,
  output logic [31:0] epc,
  output logic [31:0] rdata
);

  logic [5:0]  sr_im_q, sr_im_d;
  logic        sr_exl_q, sr_exl_d;
  logic        sr_ie_q, sr_ie_d;
  logic        cause_bd_q, cause_bd_d;
  logic [5:0]  cause_ip_q, cause_ip_d;
  logic [4:0]  cause_code_q, cause_code_d;
  logic [31:0] epc_q, epc_d;

  // Next-state: exception entry beats ERET beats MTC0; IP samples lines every cycle
  always_comb begin
    sr_im_d      = sr_im_q;
    sr_exl_d     = sr_exl_q;
    sr_ie_d      = sr_ie_q;
    cause_bd_d   = cause_bd_q;
    cause_ip_d   = hw_int;
    cause_code_d = cause_code_q;
    epc_d        = epc_q;
    if (take) begin
      sr_exl_d     = 1'b1;
      cause_bd_d   = bd;
      cause_code_d = exc_code;
      epc_d        = bd ? ((pc & WORD_MASK) - 32'd4) : (pc & WORD_MASK);
    end else if (eret_do) begin
      sr_exl_d = 1'b0;
    end else if (wr_en) begin
      if (addr == CP0_SR) begin
        sr_im_d  = wdata[SR_IM_MSB:SR_IM_LSB];
        sr_exl_d = wdata[SR_EXL_BIT];
        sr_ie_d  = wdata[SR_IE_BIT];
      end else if (addr == CP0_EPC) begin
        epc_d = wdata & WORD_MASK;
      end
    end
  end

  // Register state with asynchronous reset
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q      <= '0;
      sr_exl_q     <= 1'b0;
      sr_ie_q      <= 1'b0;
      cause_bd_q   <= 1'b0;
      cause_ip_q   <= '0;
      cause_code_q <= '0;
      epc_q        <= '0;
    end else begin
      sr_im_q      <= sr_im_d;
      sr_exl_q     <= sr_exl_d;
      sr_ie_q      <= sr_ie_d;
      cause_bd_q   <= cause_bd_d;
      cause_ip_q   <= cause_ip_d;
      cause_code_q <= cause_code_d;
      epc_q        <= epc_d;
    end
  end

  assign sr_im  = sr_im_q;
  assign sr_exl = sr_exl_q;
  assign sr_ie  = sr_ie_q;
  assign epc    = epc_q;

  // Combinational read mux; unmapped addresses read zero
  always_comb begin
    rdata = '0;
    case (addr)
      CP0_SR: begin
        rdata[SR_IM_MSB:SR_IM_LSB] = sr_im_q;
        rdata[SR_EXL_BIT]          = sr_exl_q;
        rdata[SR_IE_BIT]           = sr_ie_q;
      end
      CP0_CAUSE: begin
        rdata[CAUSE_BD_BIT]                = cause_bd_q;
        rdata[CAUSE_IP_MSB:CAUSE_IP_LSB]   = cause_ip_q;
        rdata[CAUSE_EXC_MSB:CAUSE_EXC_LSB] = cause_code_q;
      end
      CP0_EPC:  rdata = epc_q;
      CP0_PRID: rdata = PRID_VAL;
      default:  rdata = '0;
    endcase
  end

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt entry and ERET sequencer (RUN -> FLUSH -> REDIRECT).
// Optional build macro CP0_EXC_COUNT_EN adds a taken-exception counter at CP0 address 9.
module cp0_exc_ctrl
  import cp0_pkg::*;
#(
  parameter logic [31:0] HANDLER_PC   = 32'h0000_4180,
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] PRID_VAL     = 32'h1823_1051
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_m,
  input  logic [4:0]  exc_code_m,
  input  logic        bd_m,
  input  logic [31:0] pc_m,
  input  logic [5:0]  hw_int,
  input  logic        eret_m,
  input  logic        mtc0_we,
  input  logic [4:0]  cp0_addr,
  input  logic [31:0] cp0_wdata,
  output logic [31:0] cp0_rdata,
  output logic [31:0] epc_out,
  output logic        flush,
  output logic        redirect_valid,
  output logic [31:0] redirect_pc,
  output logic        busy
);

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] target_q, target_d;
  logic        eret_redir_q, eret_redir_d;

  logic [5:0]  sr_im;
  logic        sr_exl, sr_ie;
  logic [31:0] epc;
  logic [31:0] regs_rdata;
  logic        run, int_req, take, eret_do, wr_en;
  logic [4:0]  chosen_code;

  // Interrupts outrank synchronous exceptions; nothing is taken while reset is held
  assign run         = (state_q == ST_RUN);
  assign int_req     = (|(hw_int & sr_im)) & sr_ie & ~sr_exl;
  assign take        = ~reset & run & (int_req | exc_m);
  assign chosen_code = int_req ? EXC_INT : exc_code_m;
  assign eret_do     = run & eret_m & sr_exl & ~take;
  assign wr_en       = run & mtc0_we & ~take & ~eret_m;

  cp0_regs #(.PRID_VAL(PRID_VAL)) u_regs (
    .clk      (clk),
    .reset    (reset),
    .hw_int   (hw_int),
    .take     (take),
    .exc_code (chosen_code),
    .bd       (bd_m),
    .pc       (pc_m),
    .eret_do  (eret_do),
    .wr_en    (wr_en),
    .addr     (cp0_addr),
    .wdata    (cp0_wdata),
    .sr_im    (sr_im),
    .sr_exl   (sr_exl),
    .sr_ie    (sr_ie),
    .epc      (epc),
    .rdata    (regs_rdata)
  );

  // Sequencer next-state: entry loads the flush countdown, ERET goes straight to redirect
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    target_d     = target_q;
    eret_redir_d = eret_redir_q;
    case (state_q)
      ST_RUN: begin
        if (take) begin
          target_d     = HANDLER_PC;
          cnt_d        = CNT_INIT;
          eret_redir_d = 1'b0;
          state_d      = ST_FLUSH;
        end else if (eret_do) begin
          target_d     = epc;
          eret_redir_d = 1'b1;
          state_d      = ST_REDIRECT;
        end
      end
      ST_FLUSH: begin
        if (cnt_q == 4'd0) state_d = ST_REDIRECT;
        else               cnt_d   = cnt_q - 4'd1;
      end
      ST_REDIRECT: state_d = ST_RUN;
      default:     state_d = ST_RUN;
    endcase
  end

  // Sequencer registers; reset abandons any pending redirect
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_RUN;
      cnt_q        <= '0;
      target_q     <= '0;
      eret_redir_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      target_q     <= target_d;
      eret_redir_q <= eret_redir_d;
    end
  end

  assign busy           = ~run;
  assign redirect_valid = (state_q == ST_REDIRECT);
  assign redirect_pc    = target_q;
  assign flush          = take | (state_q == ST_FLUSH) | ((state_q == ST_REDIRECT) & eret_redir_q);
  assign epc_out        = epc;

`ifdef CP0_EXC_COUNT_EN
  logic [31:0] exc_cnt_q, exc_cnt_d;

  // Taken-exception counter; a take in the same cycle beats an MTC0 load
  always_comb begin
    exc_cnt_d = exc_cnt_q;
    if (take)                               exc_cnt_d = exc_cnt_q + 32'd1;
    else if (wr_en && cp0_addr == CP0_CNT)  exc_cnt_d = cp0_wdata;
  end

  // Counter register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) exc_cnt_q <= '0;
    else       exc_cnt_q <= exc_cnt_d;
  end

  assign cp0_rdata = (cp0_addr == CP0_CNT) ? exc_cnt_q : regs_rdata;
`else
  assign cp0_rdata = regs_rdata;
`endif

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Bench for cp0_exc_ctrl: directed scenarios then randomized traffic, all
// checked against a timeline-based reference model of the CP0 behaviour.
module tb_cp0_exc_ctrl;
  import cp0_pkg::*;

  localparam logic [31:0] HPC  = 32'h0000_4180;
  localparam int          FC   = 2;
  localparam logic [31:0] PRID = 32'h1823_1051;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_m;
  logic [4:0]  exc_code_m;
  logic        bd_m;
  logic [31:0] pc_m;
  logic [5:0]  hw_int;
  logic        eret_m;
  logic        mtc0_we;
  logic [4:0]  cp0_addr;
  logic [31:0] cp0_wdata;
  logic [31:0] cp0_rdata;
  logic [31:0] epc_out;
  logic        flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int cycle_no = 0;

  always #5 clk = ~clk;

  cp0_exc_ctrl #(.HANDLER_PC(HPC), .FLUSH_CYCLES(FC), .PRID_VAL(PRID)) dut (
    .clk            (clk),
    .reset          (reset),
    .exc_m          (exc_m),
    .exc_code_m     (exc_code_m),
    .bd_m           (bd_m),
    .pc_m           (pc_m),
    .hw_int         (hw_int),
    .eret_m         (eret_m),
    .mtc0_we        (mtc0_we),
    .cp0_addr       (cp0_addr),
    .cp0_wdata      (cp0_wdata),
    .cp0_rdata      (cp0_rdata),
    .epc_out        (epc_out),
    .flush          (flush),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .busy           (busy)
  );

  // Reference model: architectural registers plus a "cycles of busy left" timeline
  logic [5:0]  m_im;
  logic        m_exl, m_ie, m_bd;
  logic [5:0]  m_ip;
  logic [4:0]  m_code;
  logic [31:0] m_epc, m_tgt, m_cnt;
  int          busy_left;
  bit          eret_mode;

  task automatic model_reset();
    m_im = '0; m_exl = 0; m_ie = 0; m_bd = 0; m_ip = '0; m_code = '0;
    m_epc = '0; m_tgt = '0; m_cnt = '0; busy_left = 0; eret_mode = 0;
  endtask

  function automatic logic [31:0] m_rdata(input logic [4:0] a);
    logic [31:0] r;
    r = '0;
    case (a)
      5'd12: begin r[15:10] = m_im; r[1] = m_exl; r[0] = m_ie; end
      5'd13: begin r[31] = m_bd; r[15:10] = m_ip; r[6:2] = m_code; end
      5'd14: r = m_epc;
      5'd15: r = PRID;
`ifdef CP0_EXC_COUNT_EN
      5'd9:  r = m_cnt;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check 1 time unit later, advance model, wait for next negedge
  task automatic step(input logic e, input logic [4:0] code, input logic bd, input logic [31:0] pc,
                      input logic [5:0] hw, input logic er, input logic we,
                      input logic [4:0] addr, input logic [31:0] wd);
    bit idle, ireq, tk, exp_flush;
    exc_m = e; exc_code_m = code; bd_m = bd; pc_m = pc; hw_int = hw;
    eret_m = er; mtc0_we = we; cp0_addr = addr; cp0_wdata = wd;
    #1;
    idle      = (busy_left == 0);
    ireq      = (|(hw & m_im)) && m_ie && !m_exl;
    tk        = idle && (ireq || e);
    exp_flush = tk || (!eret_mode && busy_left > 1) || (eret_mode && busy_left == 1);
    $display("cyc %0d exc=%0b code=%0d bd=%0b pc=%h hw=%b eret=%0b we=%0b addr=%0d wd=%h -> flush=%0b busy=%0b rv=%0b rpc=%h rd=%h",
             cycle_no, e, code, bd, pc, hw, er, we, addr, wd, flush, busy, redirect_valid, redirect_pc, cp0_rdata);
    check("flush", {31'b0, flush}, {31'b0, exp_flush});
    check("busy", {31'b0, busy}, {31'b0, busy_left > 0});
    check("redirect_valid", {31'b0, redirect_valid}, {31'b0, busy_left == 1});
    if (busy_left == 1) check("redirect_pc", redirect_pc, m_tgt);
    check("cp0_rdata", cp0_rdata, m_rdata(addr));
    check("epc_out", epc_out, m_epc);
    // advance the model across the coming clock edge
    if (busy_left > 0) busy_left--;
    m_ip = hw;
    if (tk) begin
      m_exl = 1; m_bd = bd; m_code = ireq ? EXC_INT : code;
      m_epc = bd ? ((pc & 32'hFFFF_FFFC) - 32'd4) : (pc & 32'hFFFF_FFFC);
      m_tgt = HPC; busy_left = FC + 1; eret_mode = 0; m_cnt = m_cnt + 1;
    end else if (idle && er) begin
      if (m_exl) begin m_exl = 0; m_tgt = m_epc; busy_left = 1; eret_mode = 1; end
    end else if (idle && we) begin
      if (addr == 5'd12) begin m_im = wd[15:10]; m_exl = wd[1]; m_ie = wd[0]; end
      else if (addr == 5'd14) m_epc = wd & 32'hFFFF_FFFC;
`ifdef CP0_EXC_COUNT_EN
      else if (addr == 5'd9) m_cnt = wd;
`endif
    end
    @(negedge clk);
    cycle_no++;
  endtask

  task automatic idle_n(input int n, input logic [4:0] addr, input logic [5:0] hw);
    for (int i = 0; i < n; i++) step(0, 5'd0, 0, 32'h0, hw, 0, 0, addr, 32'h0);
  endtask

  task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
    cp0_addr = addr;
    #1;
    check(tag, cp0_rdata, exp);
  endtask

  initial begin
    reset = 1'b1;
    exc_m = 0; exc_code_m = '0; bd_m = 0; pc_m = '0; hw_int = '0;
    eret_m = 0; mtc0_we = 0; cp0_addr = 5'd12; cp0_wdata = '0;
    model_reset();
    #1;
    check("rst_flush", {31'b0, flush}, 32'h0);
    check("rst_busy", {31'b0, busy}, 32'h0);
    check("rst_rv", {31'b0, redirect_valid}, 32'h0);
    check("rst_rpc", redirect_pc, 32'h0);
    check("rst_epc", epc_out, 32'h0);
    peek("rst_sr", CP0_SR, 32'h0);
    peek("rst_cause", CP0_CAUSE, 32'h0);
    peek("rst_prid", CP0_PRID, PRID);
    @(negedge clk); @(negedge clk);
    reset = 1'b0;

    // synchronous exception, not in a delay slot
    step(1, EXC_RI, 0, 32'h3010, 6'd0, 0, 0, CP0_EPC, 32'h0);
    idle_n(3, CP0_CAUSE, 6'd0);
    check("t1_epc", epc_out, 32'h3010);
    peek("t1_cause", CP0_CAUSE, 32'h0000_0028);

    // exception in a branch delay slot
    step(1, EXC_OV, 1, 32'h3024, 6'd0, 0, 0, CP0_CAUSE, 32'h0);
    idle_n(3, CP0_EPC, 6'd0);
    check("t2_epc", epc_out, 32'h3020);
    peek("t2_cause", CP0_CAUSE, 32'h8000_0030);

    // interrupt beats a concurrent AdEL; a second exception during FLUSH is ignored
    step(0, 5'd0, 0, 32'h0, 6'd0, 0, 1, CP0_SR, 32'h0000_0401);
    step(1, EXC_ADEL, 0, 32'h3100, 6'd1, 0, 0, CP0_SR, 32'h0);
    step(1, EXC_RI, 0, 32'h3200, 6'd1, 0, 0, CP0_CAUSE, 32'h0);
    idle_n(2, CP0_CAUSE, 6'd1);
    peek("t3_cause", CP0_CAUSE, 32'h0000_0400);
    check("t3_epc", epc_out, 32'h3100);

    // ERET with EXL set redirects to EPC next cycle; a second ERET is a no-op
    step(0, 5'd0, 0, 32'h0, 6'd0, 0, 1, CP0_EPC, 32'h0000_3008);
    step(0, 5'd0, 0, 32'h0, 6'd0, 1, 0, CP0_SR, 32'h0);
    check("t4_rpc", redirect_pc, 32'h3008);
    step(0, 5'd0, 0, 32'h0, 6'd0, 0, 0, CP0_SR, 32'h0);
    step(0, 5'd0, 0, 32'h0, 6'd0, 1, 0, CP0_SR, 32'h0);
    idle_n(2, CP0_SR, 6'd0);

    // MTC0 concurrent with a take is dropped; EPC write drops the low bits
    step(1, EXC_RI, 0, 32'h3300, 6'd0, 0, 1, CP0_SR, 32'hFFFF_FFFF);
    idle_n(3, CP0_SR, 6'd0);
    peek("t5_sr", CP0_SR, 32'h0000_0403);
    step(0, 5'd0, 0, 32'h0, 6'd0, 1, 0, CP0_SR, 32'h0);
    idle_n(1, CP0_SR, 6'd0);
    step(0, 5'd0, 0, 32'h0, 6'd0, 0, 1, CP0_EPC, 32'h0000_3003);
    peek("t5_epcw", CP0_EPC, 32'h0000_3000);

    // reset asserted mid-FLUSH drops outputs without a clock edge
    step(1, EXC_ADES, 0, 32'h3400, 6'd0, 0, 0, CP0_SR, 32'h0);
    step(0, 5'd0, 0, 32'h0, 6'd0, 0, 0, CP0_SR, 32'h0);
    #2;
    reset = 1'b1;
    #1;
    check("t6_flush", {31'b0, flush}, 32'h0);
    check("t6_busy", {31'b0, busy}, 32'h0);
    check("t6_rv", {31'b0, redirect_valid}, 32'h0);
    check("t6_epc", epc_out, 32'h0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    idle_n(4, CP0_SR, 6'd0);

    // three takes for the counter
    for (int k = 0; k < 3; k++) begin
      step(1, EXC_RI, 0, 32'h3500 + 32'(k * 4), 6'd0, 0, 0, CP0_CNT, 32'h0);
      idle_n(3, CP0_CNT, 6'd0);
    end
`ifdef CP0_EXC_COUNT_EN
    peek("t7_cnt", CP0_CNT, 32'd3);
`else
    peek("t7_cnt", CP0_CNT, 32'd0);
`endif

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [4:0] ra;
      logic [5:0] hw;
      case ($urandom_range(0, 6))
        0: ra = CP0_SR;
        1: ra = CP0_CAUSE;
        2: ra = CP0_EPC;
        3: ra = CP0_PRID;
        4: ra = CP0_CNT;
        default: ra = 5'($urandom);
      endcase
      hw = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
      step($urandom_range(0, 7) == 0, 5'($urandom), 1'($urandom), $urandom, hw,
           $urandom_range(0, 5) == 0, $urandom_range(0, 4) == 0, ra, $urandom);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
